// File: rtl/mux_sched_pkg.sv
// Shared types and sizes for the round-robin mux scheduler.
// The requester count and select width are fixed by the 4:1 mux the scheduler sits in front of.
package mux_sched_pkg;

    typedef enum logic {IDLE, GRANT} sched_state_t;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or after ptr,
// scanning circularly 0->1->2->3->0.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] reqDbl;
    logic [N_REQ-1:0]   reqRot;
    logic [SEL_W-1:0]   offset;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then add ptr back (mod N_REQ).
    always_comb begin
        reqDbl = {req, req};
        reqRot = reqDbl[ptr +: N_REQ];
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (reqRot[i]) begin
                offset = SEL_W'(i);
            end
        end
        found = |req;
        idx   = offset + ptr;
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux between four requesters, with a registered
// one-hot grant, glitch-free registered select and a per-tenure burst limit.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [CNT_W-1:0] owner_cnt
);

    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] pickPtr;
    logic             pickFound;
    logic [SEL_W-1:0] pickIdx;
    logic             ownerReq;
    logic             burstDone;

    // While granting, the picker already looks from owner+1, so a release re-arbitrates in the same cycle.
    assign pickPtr   = (state_q == GRANT) ? sel_q + 1'b1 : ptr_q;
    assign ownerReq  = req[sel_q];
    assign burstDone = (cnt_q == CNT_W'(MAX_BURST));

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (pickPtr),
        .found (pickFound),
        .idx   (pickIdx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        unique case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << pickIdx;
                    sel_d   = pickIdx;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (ownerReq && !burstDone) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    ptr_d = sel_q + 1'b1;
                    if (pickFound) begin
                        gnt_d = N_REQ'(1) << pickIdx;
                        sel_d = pickIdx;
                        cnt_d = CNT_W'(1);
                    end else begin
                        // sel is deliberately held so the mux output does not toggle while idle.
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);
    assign owner_cnt = cnt_q;

    aOneHot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    aBusyGnt:  assert property (@(posedge clk) disable iff (!rst_n) busy == (gnt_q != '0));
    aSelGnt:   assert property (@(posedge clk) disable iff (!rst_n) busy |-> (gnt_q == (N_REQ'(1) << sel_q)));
    aCntMax:   assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_W'(MAX_BURST));
    aCntIdle:  assert property (@(posedge clk) disable iff (!rst_n) (cnt_q == '0) == !busy);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed self-checking bench for mux_rr_sched with MAX_BURST=8; expected values are hand-derived.
module tb_mux_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] owner_cnt;
    logic [3:0] muxIn;
    logic       y;

    int checks = 0;
    int errors = 0;

    mux_rr_sched #(.MAX_BURST(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .owner_cnt (owner_cnt)
    );

    // The shared 4:1 mux the scheduler steers.
    assign y = muxIn[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic [1:0] expSel,
                               input logic expBusy, input logic [7:0] expCnt);
        checkVal({tag, ".gnt"},  32'(gnt),       32'(expGnt));
        checkVal({tag, ".sel"},  32'(sel),       32'(expSel));
        checkVal({tag, ".busy"}, 32'(busy),      32'(expBusy));
        checkVal({tag, ".cnt"},  32'(owner_cnt), 32'(expCnt));
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        muxIn = 4'b0000;
        #12;
        checkOutput("reset", 4'b0000, 2'b00, 1'b0, 8'd0);
        rst_n = 1'b1;

        tick();
        checkOutput("idle0", 4'b0000, 2'b00, 1'b0, 8'd0);

        // Single requester 2: one-cycle latency, mux follows input c.
        applyStimulus(4'b0100);
        muxIn = 4'b0100;
        tick();
        checkOutput("first2", 4'b0100, 2'b10, 1'b1, 8'd1);
        checkVal("muxY_c1", 32'(y), 32'd1);
        muxIn = 4'b1011;
        #1;
        checkVal("muxY_c0", 32'(y), 32'd0);

        // Sole requester across two burst expiries: 1..8,1..8,1..4 with no bubble.
        for (int k = 2; k <= 20; k++) begin
            tick();
            checkOutput($sformatf("sole2_%0d", k), 4'b0100, 2'b10, 1'b1, 8'(((k - 1) % 8) + 1));
        end

        applyStimulus(4'b0000);
        tick();
        checkOutput("drop2", 4'b0000, 2'b10, 1'b0, 8'd0);

        // Fresh reset so the pointer restarts at 0 for the full rotation.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset2", 4'b0000, 2'b00, 1'b0, 8'd0);
        rst_n = 1'b1;

        applyStimulus(4'b1111);
        for (int n = 0; n < 40; n++) begin
            tick();
            checkOutput($sformatf("rot_%0d", n), 4'(1 << ((n / 8) % 4)), 2'((n / 8) % 4), 1'b1, 8'((n % 8) + 1));
        end

        // Owner 0 expires into owner 1; owner 1 then drops after 3 cycles and 3 beats pending 0.
        applyStimulus(4'b1011);
        tick();
        checkOutput("own1_c1", 4'b0010, 2'b01, 1'b1, 8'd1);
        tick();
        tick();
        checkOutput("own1_c3", 4'b0010, 2'b01, 1'b1, 8'd3);
        applyStimulus(4'b1001);
        tick();
        checkOutput("handoff3", 4'b1000, 2'b11, 1'b1, 8'd1);

        applyStimulus(4'b0010);
        tick();
        checkOutput("handoff1", 4'b0010, 2'b01, 1'b1, 8'd1);
        applyStimulus(4'b0000);
        tick();
        checkOutput("allDrop", 4'b0000, 2'b01, 1'b0, 8'd0);
        tick();
        checkOutput("idleHold", 4'b0000, 2'b01, 1'b0, 8'd0);

        // Async reset mid-tenure of owner 3 at owner_cnt=5.
        applyStimulus(4'b1000);
        tick();
        checkOutput("own3_c1", 4'b1000, 2'b11, 1'b1, 8'd1);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("own3_c5", 4'b1000, 2'b11, 1'b1, 8'd5);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst", 4'b0000, 2'b00, 1'b0, 8'd0);
        applyStimulus(4'b1010);
        tick();
        checkOutput("rstHeld", 4'b0000, 2'b00, 1'b0, 8'd0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("afterRst", 4'b0010, 2'b01, 1'b1, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
